systolic_out_collector: RTL and testbench
=========================================

# systolic_out_collector

Output-side stage placed directly downstream of the systolic convolution top. It takes the per-column results `systolic_out[col]`, which arrive on staggered cycles qualified by the per-column `out_en` strobes, and reassembles them into complete column-aligned result vectors. It buffers those vectors in a small FIFO and presents them to the feature-map writer over a valid/ready handshake. It also reports the end of a convolution once all results have drained, and flags lost or malformed data with sticky error bits.

## Interface
- `width`, 8, bit width of one result element
- `col`, 3, number of array columns; equals the element count of one vector
- `DEPTH`, 4, FIFO depth in vectors; must be at least 2
- `clk` input 1: single clock, rising edge
- `nrst` input 1: asynchronous, active-low reset
- `systolic_out` input `[width-1:0]` x `[col-1:0]`: per-column result from the array
- `out_en` input `[col-1:0]`: column c result valid this cycle
- `conv_finish` input 1: convolution complete, may be a single-cycle pulse
- `clear_err` input 1: synchronous clear of all sticky error bits
- `out_data` output `[width-1:0]` x `[col-1:0]`: vector at the FIFO head
- `out_valid` output 1: `out_data` is valid
- `out_ready` input 1: consumer accepts the vector this cycle
- `occupancy` output `$clog2(DEPTH+1)`: number of vectors stored
- `frame_done` output 1: one-cycle pulse, convolution fully drained
- `err_overflow` output 1: sticky, a completed vector was dropped because the FIFO was full
- `err_dup` output 1: sticky, a column strobed twice within one vector
- `err_partial` output 1: sticky, `conv_finish` arrived while a vector was incomplete

## Operation
- **Assembly stage.** Holds a `col`-wide holding register plus a `captured[col-1:0]` mask.
- **Column capture.** In any cycle where `out_en[c]` is 1 and `captured[c]` is 0: load `systolic_out[c]` into slot c and set `captured[c]`.
- **Duplicate strobe.** If `out_en[c]` is 1 and `captured[c]` is already 1: drop the new value, keep the slot unchanged, set `err_dup`.
- **Vector completion.** A vector completes in the cycle where (`captured` | newly-accepted strobes) is all ones.
  - The assembled vector, including same-cycle captures, is written to the FIFO at that edge.
  - `captured` clears to 0 at the same edge.
  - All columns may strobe in the same cycle; the vector then completes in that one cycle.
- **Push rule.** A push is allowed if `occupancy < DEPTH`, or if a pop occurs in the same cycle.
  - Otherwise the vector is discarded and `err_overflow` is set.
  - `captured` still clears in the discard case.
- **Pop.** Occurs when `out_valid` and `out_ready` are both 1. `out_valid` = (`occupancy` != 0).
- **FIFO structure.** Circular buffer with read and write pointers that wrap modulo `DEPTH`. `out_data` is read combinationally from the head entry.
- **conv_finish handling.**
  - Sets an internal `pending_done` flag.
  - If `captured` is non-zero and that cycle does not complete the vector, the partial vector is discarded, `captured` clears, and `err_partial` is set.
- **frame_done.** Pulses for exactly one cycle when all of the following hold: `pending_done` = 1, `occupancy` = 0, no push this cycle, and `captured` = 0. `pending_done` clears with the pulse.
  - If `conv_finish` reasserts while `pending_done` is set, the two merge and produce a single pulse.
- **Error bits.** `clear_err` clears all three sticky bits. If a set event and `clear_err` occur in the same cycle, the set wins.
- **Reset.** Asserting `nrst` low asynchronously clears all state, including during an active transfer or partial assembly. All outputs go to 0; the `out_data` reset value is 0.

## Timing
- Assembly-to-output latency: the vector completes at edge N. If the FIFO was empty, `out_valid` = 1 during cycle N+1.
- Throughput: one vector per cycle, in and out.
- Simultaneous push and pop when full: `occupancy` stays at `DEPTH` and no data is lost.
- Simultaneous push and pop when empty: the pushed vector appears at the head in the next cycle. `out_valid` is 0 in the current cycle, so the pop does not occur.
- `out_data` and `out_valid` are stable while `out_valid` = 1 and `out_ready` = 0.
- `frame_done` is asserted at the earliest one cycle after the `conv_finish` edge. It fires only after the last vector has been popped.
- Counters and pointers use no-overflow widths. `occupancy` never exceeds `DEPTH`.

## Test plan
- Staggered strobes: col=3, `out_en` = 001, 010, 100 on consecutive cycles with data 5, 6, 7 and `out_ready` = 1 -> one vector {7,6,5}, `out_valid` high one cycle after the third strobe, `occupancy` returns to 0.
- Backpressure fill: `out_ready` = 0, 5 full vectors, DEPTH=4 -> `occupancy` = 4, 5th vector dropped, `err_overflow` = 1. Then `out_ready` = 1 -> first 4 vectors out in order; `clear_err` -> `err_overflow` = 0.
- Full with concurrent pop: FIFO at 4, `out_ready` = 1 on the cycle a vector completes -> no overflow, `occupancy` stays 4, order preserved across pointer wrap.
- Duplicate strobe: `out_en` = 001 (data 9), then 001 (data 3), then 110 -> vector slot 0 = 9, `err_dup` = 1.
- Partial on finish: `out_en` = 011, then `conv_finish` -> `err_partial` = 1, nothing pushed, `frame_done` pulses the next cycle for exactly one cycle.
- Reset mid-drain: 3 vectors queued, `nrst` low asynchronously -> all outputs 0 immediately. After release, new vectors are collected correctly and no stale data appears.

Source files
------------

// File: rtl/systolic_out_collector.sv
// systolic_out_collector
//   Reassembles staggered per-column results from the systolic array into
//   column-aligned vectors, buffers them in a small circular FIFO and hands
//   them to the feature-map writer over valid/ready. Signals end-of-frame
//   once everything has drained and keeps sticky error flags.
//
// Ports
//   clk, nrst        : clock (rising edge), asynchronous active-low reset
//   systolic_out     : per-column result, slot c valid when out_en[c]
//   out_en           : per-column capture strobes
//   conv_finish      : convolution complete (may be a one-cycle pulse)
//   clear_err        : synchronous clear of the sticky error bits
//   out_data         : vector at the FIFO head (0 when empty)
//   out_valid        : FIFO non-empty
//   out_ready        : consumer accepts the head vector
//   occupancy        : number of stored vectors
//   frame_done       : one-cycle pulse, convolution fully drained
//   err_overflow     : completed vector dropped, FIFO full
//   err_dup          : a column strobed twice within one vector
//   err_partial      : conv_finish arrived with an incomplete vector
module systolic_out_collector #(
    parameter int width = 8,
    parameter int col   = 3,
    parameter int DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             nrst,
    input  logic [col-1:0][width-1:0]        systolic_out,
    input  logic [col-1:0]                   out_en,
    input  logic                             conv_finish,
    input  logic                             clear_err,
    output logic [col-1:0][width-1:0]        out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [$clog2(DEPTH+1)-1:0]       occupancy,
    output logic                             frame_done,
    output logic                             err_overflow,
    output logic                             err_dup,
    output logic                             err_partial
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [col-1:0][width-1:0] hold;
    logic [col-1:0][width-1:0] assembled;
    logic [col-1:0]            captured;
    logic [col-1:0]            accept;
    logic [col-1:0]            cap_all;

    logic [col-1:0][width-1:0] mem [DEPTH];
    logic [PTR_W-1:0]          rd_ptr;
    logic [PTR_W-1:0]          wr_ptr;

    logic complete, dup_hit, pop, room, push, ovf_hit, part_hit;
    logic pending_done;

    // Only columns not yet captured in this vector are accepted; a repeat
    // strobe leaves the slot untouched and is reported as a duplicate.
    assign accept   = out_en & ~captured;
    assign cap_all  = captured | accept;
    assign complete = &cap_all;
    assign dup_hit  = |(out_en & captured);

    always_comb begin
        assembled = hold;
        for (int c = 0; c < col; c++) begin
            if (accept[c]) assembled[c] = systolic_out[c];
        end
    end

    assign out_valid = (occupancy != '0);
    assign pop       = out_valid & out_ready;
    // A full FIFO can still take a vector when the head leaves this cycle.
    assign room      = (occupancy < OCC_W'(DEPTH)) | pop;
    assign push      = complete & room;
    assign ovf_hit   = complete & ~room;
    assign part_hit  = conv_finish & (|captured) & ~complete;

    // Head is gated so that an empty FIFO (including right after reset)
    // presents zero rather than stale storage.
    assign out_data   = out_valid ? mem[rd_ptr] : '0;
    assign frame_done = pending_done & (occupancy == '0) & ~push &
                        (captured == '0);

    // Assembly and FIFO storage: data only, qualified by captured/occupancy.
    always_ff @(posedge clk) begin
        for (int c = 0; c < col; c++) begin
            if (accept[c]) hold[c] <= systolic_out[c];
        end
        if (push) mem[wr_ptr] <= assembled;
    end

    // Control state.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            captured     <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            occupancy    <= '0;
            pending_done <= 1'b0;
            err_overflow <= 1'b0;
            err_dup      <= 1'b0;
            err_partial  <= 1'b0;
        end else begin
            // Completion (pushed or dropped) and a partial discard both
            // restart assembly from an empty mask.
            if (complete || part_hit) captured <= '0;
            else                      captured <= cap_all;

            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (push && !pop)      occupancy <= occupancy + OCC_W'(1);
            else if (pop && !push) occupancy <= occupancy - OCC_W'(1);

            // Repeated conv_finish while pending merges into one pulse.
            if (frame_done)       pending_done <= 1'b0;
            else if (conv_finish) pending_done <= 1'b1;

            // Set wins over a simultaneous clear.
            if (ovf_hit)        err_overflow <= 1'b1;
            else if (clear_err) err_overflow <= 1'b0;
            if (dup_hit)        err_dup <= 1'b1;
            else if (clear_err) err_dup <= 1'b0;
            if (part_hit)       err_partial <= 1'b1;
            else if (clear_err) err_partial <= 1'b0;
        end
    end

endmodule

// File: tb/tb_systolic_out_collector.sv
module tb_systolic_out_collector;

    localparam int W = 8;
    localparam int C = 3;
    localparam int D = 4;

    logic                  clk;
    logic                  nrst;
    logic [C-1:0][W-1:0]   systolic_out;
    logic [C-1:0]          out_en;
    logic                  conv_finish;
    logic                  clear_err;
    logic [C-1:0][W-1:0]   out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [$clog2(D+1)-1:0] occupancy;
    logic                  frame_done;
    logic                  err_overflow;
    logic                  err_dup;
    logic                  err_partial;

    systolic_out_collector #(.width(W), .col(C), .DEPTH(D)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .systolic_out (systolic_out),
        .out_en       (out_en),
        .conv_finish  (conv_finish),
        .clear_err    (clear_err),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .occupancy    (occupancy),
        .frame_done   (frame_done),
        .err_overflow (err_overflow),
        .err_dup      (err_dup),
        .err_partial  (err_partial)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [23:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard monitor: every accepted head vector is compared in order.
    always @(negedge clk) begin
        if (nrst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_vector", out_data, 32'hDEAD);
            end else begin
                chk("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    // One clock cycle of stimulus; returns 1 time unit after the edge.
    task automatic cyc(input logic [2:0] en, input logic [23:0] d, input logic fin);
        out_en       = en;
        systolic_out = d;
        conv_finish  = fin;
        @(posedge clk);
        #1;
        out_en      = '0;
        conv_finish = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(3'b000, 24'h0, 1'b0);
    endtask

    initial begin
        nrst = 1'b0; out_en = '0; systolic_out = '0; conv_finish = 1'b0;
        clear_err = 1'b0; out_ready = 1'b0;
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_data", out_data, 0);
        chk("rst_errs", {err_overflow, err_dup, err_partial}, 0);
        chk("rst_done", frame_done, 0);
        #20 nrst = 1'b1;
        @(posedge clk); #1;

        // Staggered strobes -> vector {7,6,5}
        out_ready = 1'b1;
        cyc(3'b001, 24'h000005, 1'b0);
        cyc(3'b010, 24'h000600, 1'b0);
        exp_q.push_back(24'h070605);
        cyc(3'b100, 24'h070000, 1'b0);
        chk("stag_valid", out_valid, 1);
        chk("stag_occ1", occupancy, 1);
        idle(1);
        chk("stag_occ0", occupancy, 0);

        // Backpressure fill: 5 vectors, 5th dropped
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back(24'h0A0B00 + 24'(i));
            cyc(3'b111, 24'h0A0B00 + 24'(i), 1'b0);
            if (i == 3) chk("bp_ovf_clear_at4", err_overflow, 0);
        end
        chk("bp_occ4", occupancy, 4);
        chk("bp_ovf", err_overflow, 1);
        out_ready = 1'b1;
        idle(4);
        chk("bp_drained", occupancy, 0);
        clear_err = 1'b1;
        idle(1);
        clear_err = 1'b0;
        chk("bp_ovf_cleared", err_overflow, 0);

        // Full with concurrent pop, across pointer wrap
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(24'h300000 + 24'(i * 17));
            cyc(3'b111, 24'h300000 + 24'(i * 17), 1'b0);
        end
        chk("cp_occ_full", occupancy, 4);
        out_ready = 1'b1;
        exp_q.push_back(24'h5A5A5A);
        cyc(3'b111, 24'h5A5A5A, 1'b0);
        chk("cp_occ_stay", occupancy, 4);
        chk("cp_no_ovf", err_overflow, 0);
        idle(4);
        chk("cp_drained", occupancy, 0);

        // Duplicate strobe: slot 0 keeps 9
        cyc(3'b001, 24'hEEEE09, 1'b0);
        cyc(3'b001, 24'hEEEE03, 1'b0);
        chk("dup_err", err_dup, 1);
        exp_q.push_back(24'h422109);
        cyc(3'b110, 24'h4221EE, 1'b0);
        idle(1);
        chk("dup_drained", occupancy, 0);
        clear_err = 1'b1;
        idle(1);
        clear_err = 1'b0;
        chk("dup_cleared", err_dup, 0);

        // Partial on finish
        chk("pre_done_low", frame_done, 0);
        cyc(3'b011, 24'h001122, 1'b0);
        cyc(3'b000, 24'h0, 1'b1);
        chk("part_err", err_partial, 1);
        chk("part_occ", occupancy, 0);
        chk("part_done_pulse", frame_done, 1);
        idle(1);
        chk("part_done_once", frame_done, 0);
        clear_err = 1'b1;
        idle(1);
        clear_err = 1'b0;

        // Reset mid-drain with a partial assembly in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc(3'b111, 24'hC0C0C0 + 24'(i), 1'b0);
        cyc(3'b001, 24'h0000FF, 1'b0);
        chk("rm_occ3", occupancy, 3);
        #2 nrst = 1'b0;
        #1;
        chk("rm_valid0", out_valid, 0);
        chk("rm_occ0", occupancy, 0);
        chk("rm_data0", out_data, 0);
        exp_q.delete();
        #3 nrst = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        cyc(3'b110, 24'h123400, 1'b0);
        chk("rm_no_stale", out_valid, 0);
        exp_q.push_back(24'h123456);
        cyc(3'b001, 24'h000056, 1'b0);
        chk("rm_new_valid", out_valid, 1);
        idle(2);
        chk("rm_drained", occupancy, 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
